// File: rtl/dcache_port_arbiter.sv
// rtl/dcache_port_arbiter.sv - two-slot D-cache request port arbiter with in-order response steering
// Optional performance counters: define DCACHE_ARB_PERF_EN.
module dcache_port_arbiter #(
   parameter int OUTSTANDING = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [1:0]        req_valid_i,
   input  logic [1:0]        req_we_i,
   input  logic [1:0][31:0]  req_addr_i,
   input  logic [1:0][3:0]   req_wstrb_i,
   input  logic [1:0][31:0]  req_wdata_i,
   input  logic [1:0]        req_uncached_i,
   output logic [1:0]        req_ready_o,
   output logic [1:0]        resp_data_ok_o,
   output logic [1:0][31:0]  resp_rdata_o,
   output logic              cache_valid_o,
   output logic              cache_we_o,
   output logic [31:0]       cache_addr_o,
   output logic [3:0]        cache_wstrb_o,
   output logic [31:0]       cache_wdata_o,
   output logic              cache_uncached_o,
   input  logic              cache_addr_ok_i,
   input  logic              cache_data_ok_i,
   input  logic [31:0]       cache_rdata_i,
   output logic [31:0]       perf_conflict_o,
   output logic [31:0]       perf_full_o,
   output logic [31:0]       perf_killed_o
);

   localparam int AW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam logic [AW:0] DEPTH = (AW+1)'(OUTSTANDING);

   // ID FIFO: which slot issued each outstanding request, and whether it was flushed
   logic [OUTSTANDING-1:0] fifo_id;
   logic [OUTSTANDING-1:0] fifo_kill;
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic [AW:0]            count;

   logic                   lock_valid;
   logic                   lock_id;

   logic                   full;
   logic                   empty;
   logic                   grant_en;
   logic                   grant_id;
   logic                   accept;
   logic                   pop;
   logic                   head_id;
   logic                   head_kill;
   logic                   deliver;
   logic                   kill_pop;

   assign full      = (count == DEPTH);
   assign empty     = (count == '0);
   assign head_id   = fifo_id[rd_ptr];
   assign head_kill = fifo_kill[rd_ptr];

   // Full blocks the grant even when a pop frees a slot this cycle: keeps addr_ok off the pop path
   always_comb begin
      grant_en = 1'b0;
      grant_id = 1'b0;
      if (!rst && !flush && !full) begin
         if (lock_valid) begin
            grant_en = 1'b1;
            grant_id = lock_id;
         end else if (req_valid_i[0]) begin
            grant_en = 1'b1;
            grant_id = 1'b0;
         end else if (req_valid_i[1]) begin
            grant_en = 1'b1;
            grant_id = 1'b1;
         end
      end
   end

   always_comb begin
      cache_valid_o    = 1'b0;
      cache_we_o       = 1'b0;
      cache_addr_o     = 32'h0;
      cache_wstrb_o    = 4'h0;
      cache_wdata_o    = 32'h0;
      cache_uncached_o = 1'b0;
      if (grant_en) begin
         cache_valid_o    = req_valid_i[grant_id];
         cache_we_o       = req_we_i[grant_id];
         cache_addr_o     = req_addr_i[grant_id];
         cache_wstrb_o    = req_wstrb_i[grant_id];
         cache_wdata_o    = req_wdata_i[grant_id];
         cache_uncached_o = req_uncached_i[grant_id];
      end
   end

   assign accept = cache_valid_o & cache_addr_ok_i;

   always_comb begin
      req_ready_o = 2'b00;
      if (accept) begin
         req_ready_o[grant_id] = 1'b1;
      end
   end

   // A pop in the flush cycle belongs to a request being killed, so it is swallowed too
   assign pop      = !rst & cache_data_ok_i & !empty;
   assign deliver  = pop & !head_kill & !flush;
   assign kill_pop = pop & (head_kill | flush);

   always_comb begin
      resp_data_ok_o = 2'b00;
      resp_rdata_o   = '0;
      if (deliver) begin
         resp_data_ok_o[head_id] = 1'b1;
         resp_rdata_o[head_id]   = cache_rdata_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_id   <= '0;
         fifo_kill <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
      end else begin
         if (accept) begin
            fifo_id[wr_ptr]   <= grant_id;
            fifo_kill[wr_ptr] <= 1'b0;
            wr_ptr            <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         // No grant happens during flush, so marking every entry never hits a fresh push
         if (flush) begin
            fifo_kill <= '1;
         end
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Lock pins the grant to the stalled slot so the cache never sees a request vanish
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_valid <= 1'b0;
         lock_id    <= 1'b0;
      end else if (flush) begin
         lock_valid <= 1'b0;
      end else if (cache_valid_o && !cache_addr_ok_i) begin
         lock_valid <= 1'b1;
         lock_id    <= grant_id;
      end else if (accept) begin
         lock_valid <= 1'b0;
      end
   end

`ifdef DCACHE_ARB_PERF_EN
   logic [31:0] conflict_cnt;
   logic [31:0] full_cnt;
   logic [31:0] killed_cnt;
   logic        conflict_ev;
   logic        full_ev;

   assign conflict_ev = &req_valid_i;
   assign full_ev     = (|req_valid_i) & full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conflict_cnt <= '0;
         full_cnt     <= '0;
         killed_cnt   <= '0;
      end else begin
         if (conflict_ev && conflict_cnt != 32'hFFFF_FFFF) begin
            conflict_cnt <= conflict_cnt + 32'd1;
         end
         if (full_ev && full_cnt != 32'hFFFF_FFFF) begin
            full_cnt <= full_cnt + 32'd1;
         end
         if (kill_pop && killed_cnt != 32'hFFFF_FFFF) begin
            killed_cnt <= killed_cnt + 32'd1;
         end
      end
   end

   assign perf_conflict_o = conflict_cnt;
   assign perf_full_o     = full_cnt;
   assign perf_killed_o   = killed_cnt;
`else
   logic unused_perf;
   assign unused_perf     = kill_pop;
   assign perf_conflict_o = 32'h0;
   assign perf_full_o     = 32'h0;
   assign perf_killed_o   = 32'h0;
`endif

endmodule
